// File: rtl/zx_mem_arbiter_if.sv
// Requester and RAM-side signal bundle of zx_mem_arbiter.
// The arbiter attaches to the slave modport; requesters and the RAM model attach to master.
interface zx_mem_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          vid_ack;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    logic          busy;
    logic [1:0]    grant;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_q,
        output vid_rdata, vid_ack, cpu_rdata, cpu_ack, ld_rdata, ld_ack,
        output mem_addr, mem_wdata, mem_we, busy, grant
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_q,
        input  vid_rdata, vid_ack, cpu_rdata, cpu_ack, ld_rdata, ld_ack,
        input  mem_addr, mem_wdata, mem_we, busy, grant
    );
endinterface

// File: rtl/zx_mem_arbiter.sv
// Single-port RAM sequencer for video, Z80 and loader: one access in flight,
// fixed priority vid > cpu > ld with starvation promotion of the loader.
module zx_mem_arbiter #(
    parameter int AW         = 17,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input logic             clock,
    input logic             reset_n,
    zx_mem_arbiter_if.slave bus
);
    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_VID  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_LD   = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t     state, state_nx;
    logic [2:0] wait_cnt;
    logic [7:0] starve_cnt;
    logic       acc_we;
    logic [1:0] win;
    logic       win_we;
    logic       promote;

    always_comb begin
        promote = (starve_cnt == 8'(STARVE_MAX)) && bus.ld_req;
        win     = G_NONE;
        win_we  = 1'b0;
        if (bus.vid_req)      win = G_VID;
        else if (promote)     win = G_LD;
        else if (bus.cpu_req) win = G_CPU;
        else if (bus.ld_req)  win = G_LD;
        case (win)
            G_CPU:   win_we = bus.cpu_we;
            G_LD:    win_we = bus.ld_we;
            default: win_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win != G_NONE) state_nx = ACCESS;
            ACCESS:  state_nx = WAIT;
            WAIT:    if (wait_cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.grant     <= G_NONE;
            bus.vid_rdata <= '0;
            bus.cpu_rdata <= '0;
            bus.ld_rdata  <= '0;
            bus.vid_ack   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.ld_ack    <= 1'b0;
            acc_we        <= 1'b0;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
        end else begin
            bus.vid_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.ld_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.ld_req) starve_cnt <= '0;
                    case (win)
                        G_VID: bus.mem_addr <= bus.vid_addr;
                        G_CPU: begin
                            bus.mem_addr  <= bus.cpu_addr;
                            bus.mem_wdata <= bus.cpu_wdata;
                            if (bus.ld_req && starve_cnt < 8'(STARVE_MAX))
                                starve_cnt <= starve_cnt + 8'd1;
                        end
                        G_LD: begin
                            bus.mem_addr  <= bus.ld_addr;
                            bus.mem_wdata <= bus.ld_wdata;
                            starve_cnt    <= '0;
                        end
                        default: ;
                    endcase
                    bus.mem_we <= win_we;
                    acc_we     <= win_we;
                    bus.grant  <= win;
                end
                ACCESS: begin
                    // The RAM latches the write at the edge ending ACCESS; one cycle only.
                    bus.mem_we <= 1'b0;
                    wait_cnt   <= 3'(RD_LAT - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (!acc_we) begin
                            case (bus.grant)
                                G_VID:   bus.vid_rdata <= bus.mem_q;
                                G_CPU:   bus.cpu_rdata <= bus.mem_q;
                                G_LD:    bus.ld_rdata  <= bus.mem_q;
                                default: ;
                            endcase
                        end
                        bus.vid_ack <= (bus.grant == G_VID);
                        bus.cpu_ack <= (bus.grant == G_CPU);
                        bus.ld_ack  <= (bus.grant == G_LD);
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE:    bus.grant <= G_NONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Scoreboard bench for zx_mem_arbiter: directed requester traffic, a RAM model per
// instance, and ack monitors that pop hand-computed expectations.
module tb_zx_mem_arbiter;
    localparam int AW = 17;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    zx_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    zx_mem_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

    zx_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(8)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
    zx_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE_MAX(8)) dut3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3));

    // RAM models: 1-cycle read latency for dut, 3-cycle pipeline for dut3.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] qa, s1, s2, s3;
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        qa <= ram[bus.mem_addr];
        s1 <= ram[bus3.mem_addr];
        s2 <= s1;
        s3 <= s2;
    end
    assign bus.mem_q  = qa;
    assign bus3.mem_q = s3;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [1:0] id; logic [7:0] rdata; int cyc; } exp_t;
    typedef struct { logic we; logic [16:0] addr; logic [7:0] wdata; } tx_t;

    exp_t sb[$];
    exp_t sb3[$];
    tx_t  vq[$];
    tx_t  cq[$];
    tx_t  lq[$];
    logic cpu_drop = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        ram[a] <= d;
    endtask

    // Monitor for dut: every ack pops one expectation.
    always @(negedge clock) begin : mon
        int         n;
        logic [1:0] id;
        logic [7:0] rd;
        exp_t       e;
        if (reset_n) begin
            n = int'(bus.vid_ack) + int'(bus.cpu_ack) + int'(bus.ld_ack);
            if (n > 1) check("ack_onehot", n, 1);
            else if (n == 1) begin
                id = bus.vid_ack ? 2'd1 : (bus.cpu_ack ? 2'd2 : 2'd3);
                rd = bus.vid_ack ? bus.vid_rdata : (bus.cpu_ack ? bus.cpu_rdata : bus.ld_rdata);
                if (sb.size() == 0) check("unexpected_ack", id, 0);
                else begin
                    e = sb.pop_front();
                    check("ack_id", id, e.id);
                    check("ack_grant", bus.grant, e.id);
                    check("ack_rdata", rd, e.rdata);
                    check("ack_cycle", cyc, e.cyc);
                end
            end
            if (bus.mem_we) begin
                wr_cnt++;
                check("write_not_video", bus.grant == 2'd1, 0);
            end
        end
    end

    // Monitor for dut3 (video only).
    always @(negedge clock) begin : mon3
        exp_t e;
        if (reset_n && bus3.vid_ack) begin
            if (sb3.size() == 0) check("unexpected_ack3", 1, 0);
            else begin
                e = sb3.pop_front();
                check("ack3_rdata", bus3.vid_rdata, e.rdata);
                check("ack3_cycle", cyc, e.cyc);
            end
        end
    end

    // Requester driver: presents the queue head, pops it the cycle after its ack.
    initial begin : driver
        logic av, ac, al;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        forever begin
            @(negedge clock);
            av = bus.vid_ack; ac = bus.cpu_ack; al = bus.ld_ack;
            @(posedge clock);
            #1;
            if (av && vq.size() != 0) vq.delete(0);
            if (ac && cq.size() != 0) cq.delete(0);
            if (al && lq.size() != 0) lq.delete(0);
            if (vq.size() != 0) begin
                bus.vid_req = 1'b1; bus.vid_addr = vq[0].addr;
            end else bus.vid_req = 1'b0;
            if (cq.size() != 0 && !cpu_drop) begin
                bus.cpu_req = 1'b1; bus.cpu_we = cq[0].we;
                bus.cpu_addr = cq[0].addr; bus.cpu_wdata = cq[0].wdata;
            end else begin
                bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '1; bus.cpu_wdata = '1;
            end
            if (lq.size() != 0) begin
                bus.ld_req = 1'b1; bus.ld_we = lq[0].we;
                bus.ld_addr = lq[0].addr; bus.ld_wdata = lq[0].wdata;
            end else begin
                bus.ld_req = 1'b0; bus.ld_we = 1'b0;
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || sb3.size() != 0 || vq.size() != 0 ||
                cq.size() != 0 || lq.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({"drain_", name}, n < 200, 1);
        repeat (2) @(negedge clock);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c, w, n;
        bus3.vid_req = 1'b0; bus3.vid_addr = '0;
        bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.ld_req  = 1'b0; bus3.ld_we  = 1'b0; bus3.ld_addr  = '0; bus3.ld_wdata  = '0;
        poke(17'h0A000, 8'h5A);
        poke(17'h00010, 8'h10);
        poke(17'h00020, 8'h20);
        poke(17'h00030, 8'h30);
        poke(17'h00500, 8'h00);
        for (int i = 0; i < 9; i++) poke(17'h00600 + 17'(i), 8'h60 + 8'(i));
        poke(17'h14000, 8'h3C);
        poke(17'h1F000, 8'h44);
        poke(17'h00000, 8'hEE);
        poke(17'h00100, 8'h11);
        poke(17'h00200, 8'h22);

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_acks", {bus.vid_ack, bus.cpu_ack, bus.ld_ack}, 0);
        check("rst_rdata", {bus.vid_rdata, bus.cpu_rdata, bus.ld_rdata}, 0);
        check("rst_busy3", bus3.busy, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1: cpu read of 0x0A000
        c = cyc;
        cq.push_back('{1'b0, 17'h0A000, 8'h00});
        sb.push_back('{2'd2, 8'h5A, c + 4});
        @(negedge clock);
        check("t1_idle_busy", bus.busy, 0);
        @(negedge clock);
        check("t1_access_addr", bus.mem_addr, 17'h0A000);
        check("t1_access_grant", bus.grant, 2);
        check("t1_access_busy", bus.busy, 1);
        check("t1_access_we", bus.mem_we, 0);
        drain("t1");

        // 2: simultaneous requests resolve vid, cpu, ld; acks 4 cycles apart
        w = wr_cnt;
        c = cyc;
        vq.push_back('{1'b0, 17'h00010, 8'h00});
        cq.push_back('{1'b0, 17'h00020, 8'h00});
        lq.push_back('{1'b0, 17'h00030, 8'h00});
        sb.push_back('{2'd1, 8'h10, c + 4});
        sb.push_back('{2'd2, 8'h20, c + 8});
        sb.push_back('{2'd3, 8'h30, c + 12});
        drain("t2");
        check("t2_no_writes", wr_cnt - w, 0);

        // 3: eight cpu grants starve the loader, then the loader write is promoted
        w = wr_cnt;
        c = cyc;
        for (int i = 0; i < 9; i++) cq.push_back('{1'b0, 17'h00600 + 17'(i), 8'h00});
        lq.push_back('{1'b1, 17'h00500, 8'h77});
        for (int i = 0; i < 8; i++) sb.push_back('{2'd2, 8'h60 + 8'(i), c + 4 + 4 * i});
        sb.push_back('{2'd3, 8'h30, c + 36});
        sb.push_back('{2'd2, 8'h68, c + 40});
        drain("t3");
        check("t3_one_write", wr_cnt - w, 1);
        check("t3_ram", ram[17'h00500], 8'h77);

        // 4: cpu write whose request is withdrawn during WAIT
        w = wr_cnt;
        c = cyc;
        cq.push_back('{1'b1, 17'h14000, 8'hC3});
        sb.push_back('{2'd2, 8'h68, c + 4});
        repeat (2) @(negedge clock);
        cpu_drop = 1'b1;
        drain("t4");
        cpu_drop = 1'b0;
        check("t4_one_write", wr_cnt - w, 1);
        check("t4_ram", ram[17'h14000], 8'hC3);

        // 5: reset during ACCESS of a write
        cq.push_back('{1'b1, 17'h1F000, 8'h99});
        repeat (2) @(negedge clock);
        check("t5_access_we", bus.mem_we, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_we", bus.mem_we, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_grant", bus.grant, 0);
        cq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_busy", bus.busy, 0);
        check("t5_grant", bus.grant, 0);
        check("t5_acks", {bus.vid_ack, bus.cpu_ack, bus.ld_ack}, 0);
        check("t5_ram", ram[17'h1F000], 8'h44);

        // 6: RD_LAT=3 video reads, ack 5 cycles after sampling
        c = cyc;
        bus3.vid_addr = 17'h00100;
        bus3.vid_req  = 1'b1;
        sb3.push_back('{2'd1, 8'h11, c + 5});
        n = 0;
        while (!bus3.vid_ack && n < 20) begin @(negedge clock); n++; end
        check("t6_ack1_seen", n < 20, 1);
        @(posedge clock);
        #1;
        bus3.vid_addr = 17'h00200;
        sb3.push_back('{2'd1, 8'h22, cyc + 5});
        n = 0;
        while (!bus3.vid_ack && n < 20) begin @(negedge clock); n++; end
        check("t6_ack2_seen", n < 20, 1);
        @(posedge clock);
        #1;
        bus3.vid_req = 1'b0;
        drain("t6");
        check("t6_we3", bus3.mem_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
